// File: rtl/seq110_channel_scheduler_if.sv
// Bus bundle between NUM_CH bit-serial requesters / event logger and the
// shared "110" detector scheduler.
interface seq110_channel_scheduler_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int CNT_W  = 8
);
    logic              enable;
    logic              clear;
    logic [NUM_CH-1:0] ch_valid;
    logic [NUM_CH-1:0] ch_bit;
    logic [NUM_CH-1:0] ch_ready;
    logic              match_vld;
    logic [CH_W-1:0]   match_ch;
    logic [CH_W-1:0]   cnt_sel;
    logic [CNT_W-1:0]  cnt_out;

    // Requesters / control side
    modport master (
        output enable, clear, ch_valid, ch_bit, cnt_sel,
        input  ch_ready, match_vld, match_ch, cnt_out
    );

    // Scheduler side
    modport slave (
        input  enable, clear, ch_valid, ch_bit, cnt_sel,
        output ch_ready, match_vld, match_ch, cnt_out
    );
endinterface

// File: rtl/seq110_channel_scheduler.sv
// Round-robin scheduler sharing one "110" pattern detector among NUM_CH
// serial lanes. Each lane keeps its own detector context; a match produces a
// registered, channel-tagged pulse and bumps a saturating per-lane counter.
module seq110_channel_scheduler #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    seq110_channel_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G1   = 2'd1,
        G11  = 2'd2,
        HIT  = 2'd3
    } ctx_t;

    ctx_t             r_ctx [NUM_CH];
    logic [CNT_W-1:0] r_cnt [NUM_CH];
    logic [CH_W-1:0]  r_rr_ptr;
    logic             r_match_vld;
    logic [CH_W-1:0]  r_match_ch;

    logic [NUM_CH-1:0] w_grant;
    logic [CH_W-1:0]   w_gnt_id;
    logic [CH_W-1:0]   w_scan_idx;
    logic              w_xfer;
    logic              w_bit;
    ctx_t              w_cur;
    ctx_t              w_next;
    logic              w_hit;
    logic [CH_W-1:0]   w_rr_next;

    // Round-robin grant: scan from rr_ptr downward-priority so the closest lane wins
    always_comb begin
        w_grant    = '0;
        w_gnt_id   = '0;
        w_scan_idx = '0;
        if (bus.enable && !bus.clear && !rst) begin
            // Scan farthest-first so the nearest valid lane overwrites last
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                w_scan_idx = CH_W'((int'(r_rr_ptr) + k) % NUM_CH);
                if (bus.ch_valid[w_scan_idx]) begin
                    w_grant             = '0;
                    w_grant[w_scan_idx] = 1'b1;
                    w_gnt_id            = w_scan_idx;
                end
            end
        end
    end

    // Grant is only ever issued on a valid lane, so any grant is a transfer
    assign w_xfer    = |w_grant;
    assign w_bit     = bus.ch_bit[w_gnt_id];
    assign w_rr_next = (w_gnt_id == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_id + 1'b1;

    // Detector next-state for the granted lane's context
    always_comb begin
        w_cur  = r_ctx[w_gnt_id];
        w_next = w_cur;
        case (w_cur)
            IDLE:    w_next = w_bit ? G1  : IDLE;
            G1:      w_next = w_bit ? G11 : IDLE;
            G11:     w_next = w_bit ? G11 : HIT;
            HIT:     w_next = w_bit ? G1  : IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_hit = w_xfer && (w_next == HIT);

    // Context table, counters, round-robin pointer and match event registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_ctx[i] <= IDLE;
                r_cnt[i] <= '0;
            end
            r_rr_ptr    <= '0;
            r_match_vld <= 1'b0;
            r_match_ch  <= '0;
        end else if (bus.clear) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_ctx[i] <= IDLE;
                r_cnt[i] <= '0;
            end
            r_rr_ptr    <= '0;
            r_match_vld <= 1'b0;
        end else begin
            r_match_vld <= w_hit;
            if (w_hit) begin
                r_match_ch <= w_gnt_id;
            end
            if (w_xfer) begin
                r_ctx[w_gnt_id] <= w_next;
                r_rr_ptr        <= w_rr_next;
                if (w_hit && (r_cnt[w_gnt_id] != {CNT_W{1'b1}})) begin
                    r_cnt[w_gnt_id] <= r_cnt[w_gnt_id] + 1'b1;
                end
            end
        end
    end

    assign bus.ch_ready  = w_grant;
    assign bus.match_vld = r_match_vld;
    assign bus.match_ch  = r_match_ch;
    // cnt_sel is assumed to address an existing lane
    assign bus.cnt_out   = r_cnt[bus.cnt_sel];

endmodule

// File: tb/tb_seq110_channel_scheduler.sv
// Directed, table-driven bench for seq110_channel_scheduler (CNT_W=2 so that
// counter saturation is reachable quickly).
module tb_seq110_channel_scheduler;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 2;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    seq110_channel_scheduler_if #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

    seq110_channel_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [3:0] valid;
        logic [3:0] bits;
        logic       en;
        logic       clr;
        logic [3:0] exp_rdy;
        logic       exp_mv;
        logic [1:0] exp_mc;
        logic       chk_cnt;
        logic [1:0] cnt_ch;
        logic [1:0] exp_cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_cnt(input string name, input logic [1:0] ch, input logic [1:0] exp);
        bus.cnt_sel = ch;
        #1;
        chk(name, 32'(bus.cnt_out), 32'(exp));
    endtask

    // One clock of stimulus: drive at negedge, check grant, then check match after the edge
    task automatic step(input string tag, input logic [3:0] v, input logic [3:0] b,
                        input logic en, input logic clr, input logic [3:0] erdy,
                        input logic emv, input logic [1:0] emc);
        @(negedge clk);
        bus.ch_valid = v;
        bus.ch_bit   = b;
        bus.enable   = en;
        bus.clear    = clr;
        #1;
        chk({tag, " ready"}, 32'(bus.ch_ready), 32'(erdy));
        @(posedge clk);
        #1;
        chk({tag, " match_vld"}, 32'(bus.match_vld), 32'(emv));
        if (emv) chk({tag, " match_ch"}, 32'(bus.match_ch), 32'(emc));
        $display("%0t %s: valid=%b bit=%b en=%b clr=%b ready=%b match_vld=%b match_ch=%0d",
                 $time, tag, v, b, en, clr, bus.ch_ready, bus.match_vld, bus.match_ch);
    endtask

    task automatic add(input string tag, input logic [3:0] v, input logic [3:0] b,
                       input logic en, input logic clr, input logic [3:0] erdy,
                       input logic emv, input logic [1:0] emc,
                       input logic cc, input logic [1:0] cch, input logic [1:0] ecnt);
        vec_t t;
        t.tag = tag; t.valid = v; t.bits = b; t.en = en; t.clr = clr;
        t.exp_rdy = erdy; t.exp_mv = emv; t.exp_mc = emc;
        t.chk_cnt = cc; t.cnt_ch = cch; t.exp_cnt = ecnt;
        tbl.push_back(t);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst          = 1'b1;
        bus.enable   = 1'b1;
        bus.clear    = 1'b0;
        bus.ch_valid = 4'b1111;
        bus.ch_bit   = 4'b0000;
        bus.cnt_sel  = '0;

        // Test 1: ch0 alone, 1,1,0
        add("t1a", 4'b0001, 4'b0001, 1, 0, 4'b0001, 0, 0, 0, 0, 0);
        add("t1b", 4'b0001, 4'b0001, 1, 0, 4'b0001, 0, 0, 0, 0, 0);
        add("t1c", 4'b0001, 4'b0000, 1, 0, 4'b0001, 1, 0, 1, 0, 1);
        add("t1d", 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0, 1, 0, 1);
        // clear brings rr_ptr back to 0 and zeroes counters
        add("clr", 4'b1111, 4'b1111, 1, 1, 4'b0000, 0, 0, 1, 0, 0);
        // Test 2: all four lanes valid every cycle
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                add($sformatf("t2 r%0d c%0d", r, c), 4'b1111, (r < 2) ? 4'b1111 : 4'b0000,
                    1, 0, 4'(1 << c), (r == 2), 2'(c), (r == 2), 2'(c), 1);
            end
        end
        // Test 3: ch2 pattern 1,1,0,1,1,0 with ch1 noise 0,1,0 (rr_ptr=0, all ctx HIT)
        add("t3c0", 4'b0100, 4'b0100, 1, 0, 4'b0100, 0, 0, 0, 0, 0);
        add("t3c1", 4'b0010, 4'b0000, 1, 0, 4'b0010, 0, 0, 0, 0, 0);
        add("t3c2", 4'b0100, 4'b0100, 1, 0, 4'b0100, 0, 0, 0, 0, 0);
        add("t3c3", 4'b0110, 4'b0010, 1, 0, 4'b0010, 0, 0, 0, 0, 0);
        add("t3c4", 4'b0110, 4'b0010, 1, 0, 4'b0100, 1, 2, 1, 2, 2);
        add("t3c5", 4'b0110, 4'b0100, 1, 0, 4'b0010, 0, 0, 1, 1, 1);
        add("t3c6", 4'b0100, 4'b0100, 1, 0, 4'b0100, 0, 0, 0, 0, 0);
        add("t3c7", 4'b0100, 4'b0100, 1, 0, 4'b0100, 0, 0, 0, 0, 0);
        add("t3c8", 4'b0100, 4'b0000, 1, 0, 4'b0100, 1, 2, 1, 2, 3);
        // enable=0 blocks grants; then ch3 is granted once re-enabled
        add("en0",  4'b1000, 4'b1000, 0, 0, 4'b0000, 0, 0, 1, 3, 1);
        add("en1",  4'b1000, 4'b1000, 1, 0, 4'b1000, 0, 0, 0, 0, 0);

        // Reset state
        #1;
        chk("rst ready", 32'(bus.ch_ready), 32'(4'b0000));
        chk("rst match_vld", 32'(bus.match_vld), 32'(0));
        chk("rst match_ch", 32'(bus.match_ch), 32'(0));
        check_cnt("rst cnt0", 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].tag, tbl[i].valid, tbl[i].bits, tbl[i].en, tbl[i].clr,
                 tbl[i].exp_rdy, tbl[i].exp_mv, tbl[i].exp_mc);
            if (tbl[i].chk_cnt)
                check_cnt({tbl[i].tag, " cnt"}, tbl[i].cnt_ch, tbl[i].exp_cnt);
        end

        // Test 4: five matches on ch3, counter saturates at 3
        step("t4 clr", 4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step($sformatf("t4 m%0d b0", k), 4'b1000, 4'b1000, 1, 0, 4'b1000, 0, 0);
            step($sformatf("t4 m%0d b1", k), 4'b1000, 4'b1000, 1, 0, 4'b1000, 0, 0);
            step($sformatf("t4 m%0d b2", k), 4'b1000, 4'b0000, 1, 0, 4'b1000, 1, 3);
            check_cnt($sformatf("t4 m%0d cnt3", k), 3, (k < 3) ? 2'(k) : 2'd3);
        end

        // Test 5: clear while ch0 sits at G11 with a pending 0 bit
        step("t5 clr0", 4'b0000, 4'b0000, 1, 1, 4'b0000, 0, 0);
        step("t5 a",    4'b0001, 4'b0001, 1, 0, 4'b0001, 0, 0);
        step("t5 b",    4'b0001, 4'b0001, 1, 0, 4'b0001, 0, 0);
        step("t5 clr",  4'b0001, 4'b0000, 1, 1, 4'b0000, 0, 0);
        check_cnt("t5 cnt0", 0, 0);
        // rr_ptr back at 0 picks ch0 over ch3; ch0 IDLE so a 0 gives no match
        step("t5 post", 4'b1001, 4'b0000, 1, 0, 4'b0001, 0, 0);

        // Test 6: async reset mid-stream with ch1 at G11 and a ch3 match pulse live
        step("t6 a", 4'b0010, 4'b0010, 1, 0, 4'b0010, 0, 0);
        step("t6 b", 4'b0010, 4'b0010, 1, 0, 4'b0010, 0, 0);
        step("t6 c", 4'b1000, 4'b1000, 1, 0, 4'b1000, 0, 0);
        step("t6 d", 4'b1000, 4'b1000, 1, 0, 4'b1000, 0, 0);
        step("t6 e", 4'b1000, 4'b0000, 1, 0, 4'b1000, 1, 3);
        bus.ch_valid = 4'b0010;
        bus.ch_bit   = 4'b0000;
        #1;
        rst = 1'b1;
        #1;
        chk("t6 rst match_vld", 32'(bus.match_vld), 32'(0));
        chk("t6 rst match_ch", 32'(bus.match_ch), 32'(0));
        chk("t6 rst ready", 32'(bus.ch_ready), 32'(4'b0000));
        check_cnt("t6 rst cnt3", 3, 0);
        rst = 1'b0;
        step("t6 post", 4'b0010, 4'b0000, 1, 0, 4'b0010, 0, 0);
        step("t6 idle", 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
